// File: rtl/rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rr_stream_arbiter
//
// Round-robin arbiter that merges N packetised valid/ready streams into one
// registered valid/ready output stage. A requester that wins arbitration keeps
// the grant until its last beat is accepted; priority then rotates to the
// requester after it. Arbitration is zero-cycle and the output register gives
// one cycle of latency at full throughput, including back-to-back packets from
// different requesters.
//
// Ports:
//   sys_clk    - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   req_valid  - per-requester beat valid                      [N]
//   req_data   - packed beat data, requester i at [i*DW +: DW] [N*DW]
//   req_last   - per-requester last-beat-of-packet flag        [N]
//   req_ready  - per-requester accept, one-hot or zero          [N]
//   out_valid  - registered downstream valid
//   out_data   - registered downstream data                     [DW]
//   out_last   - registered downstream last flag
//   out_src    - registered index of the requester that sourced the beat [SW]
//   out_ready  - downstream accept
//   locked     - high while a multi-beat packet holds the grant
// -----------------------------------------------------------------------------
module rr_stream_arbiter #(
    parameter  int N  = 4,
    parameter  int DW = 3,
    localparam int SW = $clog2(N)
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_src,
    input  logic            out_ready,
    output logic            locked
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   owner_q, owner_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [SW-1:0]   out_src_q, out_src_d;

    logic            load_en;
    logic            grant_ok;
    logic            xfer;
    logic [SW-1:0]   winner;
    logic [SW-1:0]   idle_winner;
    logic [DW-1:0]   sel_data;
    logic            sel_last;

    // (base + off) mod N, for base < N and 0 <= off < N.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return SW'(sum);
    endfunction

    // The output register can take a new beat when it is empty or being drained.
    assign load_en = ~out_valid_q | out_ready;

    // Rotating priority scan: walk from the farthest offset back to ptr so the
    // last hit (closest to ptr) wins.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        idle_winner = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(ptr_q, k)]) idle_winner = wrap_add(ptr_q, k);
        end
    end

    always_comb begin
        winner   = idle_winner;
        grant_ok = |req_valid;
        if (state_q == LOCKED) begin
            winner   = owner_q;
            grant_ok = req_valid[owner_q];
        end
    end

    // A granted, valid beat is always accepted when the output stage can load.
    assign xfer = load_en & grant_ok;

    always_comb begin
        req_ready = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (winner == SW'(i)) begin
                req_ready[i] = xfer;
                sel_data     = req_data[i*DW +: DW];
                sel_last     = req_last[i];
            end
        end
    end

    // Packet-lock state machine and priority pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (xfer) begin
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = wrap_add(winner, 1);
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = winner;
            end
        end
    end

    // Output register: load the granted beat, or empty out when drained with
    // nothing to replace it; otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = sel_data;
                out_last_d = sel_last;
                out_src_d  = winner;
            end
        end
    end

    // NOTE: the asynchronous reset clears every flop, datapath included, so a
    // reset mid-packet drops the in-flight beat and output reads as all-zero.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_stream_arbiter
//
// Directed bench for rr_stream_arbiter (N=4, DW=3). The stimulus process pushes
// hand-computed expected beats {src, data, last} into a queue; an independent
// monitor pops and compares on every downstream handshake. The stimulus process
// also checks req_ready / locked / stall / reset behaviour cycle by cycle.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_rr_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 3;
    localparam int SW = 2;

    logic            sys_clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [SW-1:0]   out_src;
    logic            out_ready;
    logic            locked;

    rr_stream_arbiter #(.N(N), .DW(DW)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .locked    (locked)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int src, input int data, input bit last);
        beat_t b;
        b.src  = SW'(src);
        b.data = DW'(data);
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
        req_valid[i]         = v;
        req_data[i*DW +: DW] = d;
        req_last[i]          = l;
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        next_cycle();
    endtask

    // Monitor: every downstream handshake must match the next expected beat.
    always @(negedge sys_clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got src=%0d data=%0h last=%0b expected none",
                         out_src, out_data, out_last);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_src",  32'(out_src),  32'(e.src));
                check("beat_data", 32'(out_data), 32'(e.data));
                check("beat_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b1;

        // ---------------- reset state ----------------
        @(negedge sys_clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  32'(out_data),  0);
        check("rst_out_last",  32'(out_last),  0);
        check("rst_out_src",   32'(out_src),   0);
        check("rst_locked",    32'(locked),    0);
        check("rst_req_ready", 32'(req_ready), 0);
        #1 rst_n = 1'b1;
        next_cycle();

        // ---------------- all requesting, single-beat packets ----------------
        for (int i = 0; i < N; i++) set_req(i, 1'b1, DW'(i + 1), 1'b1);
        push(0, 1, 1); push(1, 2, 1); push(2, 3, 1); push(3, 4, 1); push(0, 1, 1);
        @(negedge sys_clk);
        check("t1_first_ready",   32'(req_ready), 32'h1);
        check("t1_first_latency", 32'(out_valid), 0);
        for (int k = 1; k < 5; k++) begin
            next_cycle();
            @(negedge sys_clk);
            check("t1_rotate_ready", 32'(req_ready), 32'(1 << (k % N)));
            check("t1_out_valid",    32'(out_valid), 1);
        end
        next_cycle();
        req_valid = '0;
        do_reset();

        // ---------------- requesters 1 and 3 only ----------------
        set_req(1, 1'b1, 3'h5, 1'b1);
        set_req(3, 1'b1, 3'h6, 1'b1);
        push(1, 5, 1); push(3, 6, 1); push(1, 5, 1);
        @(negedge sys_clk); check("t2_ready_a", 32'(req_ready), 32'b0010);
        next_cycle();
        @(negedge sys_clk); check("t2_ready_b", 32'(req_ready), 32'b1000);
        next_cycle();
        @(negedge sys_clk); check("t2_ready_c", 32'(req_ready), 32'b0010);
        next_cycle();
        // ptr now 2

        // ---------------- 3-beat packet from requester 2 ----------------
        set_req(0, 1'b1, 3'h1, 1'b1);
        set_req(1, 1'b1, 3'h2, 1'b1);
        set_req(2, 1'b1, 3'h7, 1'b0);
        set_req(3, 1'b1, 3'h4, 1'b1);
        push(2, 7, 0); push(2, 6, 0); push(2, 5, 1); push(3, 4, 1);
        @(negedge sys_clk);
        check("t3_ready_b1",  32'(req_ready), 32'b0100);
        check("t3_locked_b1", 32'(locked), 0);
        next_cycle();
        set_req(2, 1'b1, 3'h6, 1'b0);
        @(negedge sys_clk);
        check("t3_ready_b2",  32'(req_ready), 32'b0100);
        check("t3_locked_b2", 32'(locked), 1);
        next_cycle();
        set_req(2, 1'b1, 3'h5, 1'b1);
        @(negedge sys_clk);
        check("t3_ready_b3",  32'(req_ready), 32'b0100);
        check("t3_locked_b3", 32'(locked), 1);
        next_cycle();
        @(negedge sys_clk);
        check("t3_next_grant", 32'(req_ready), 32'b1000);
        check("t3_unlocked",   32'(locked), 0);
        next_cycle();
        req_valid = '0;
        req_last  = '0;
        // ptr now 0

        // ---------------- downstream stall ----------------
        set_req(0, 1'b1, 3'h5, 1'b1);
        push(0, 5, 1); push(0, 6, 1);
        @(negedge sys_clk); check("t4_ready_pre", 32'(req_ready), 32'b0001);
        next_cycle();
        out_ready = 1'b0;
        set_req(0, 1'b1, 3'h6, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            check("t4_stall_valid", 32'(out_valid), 1);
            check("t4_stall_data",  32'(out_data),  32'h5);
            check("t4_stall_ready", 32'(req_ready), 0);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge sys_clk); check("t4_release_ready", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = '0;
        @(negedge sys_clk);
        check("t4_next_valid", 32'(out_valid), 1);
        check("t4_next_data",  32'(out_data),  32'h6);
        next_cycle();
        // ptr now 1

        // ---------------- owner stalls mid-packet ----------------
        set_req(0, 1'b1, 3'h3, 1'b1);
        set_req(1, 1'b1, 3'h1, 1'b0);
        push(1, 1, 0); push(1, 2, 1); push(0, 3, 1);
        @(negedge sys_clk);
        check("t5_ready_start", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge sys_clk);
            check("t5_gap_ready",  32'(req_ready), 0);
            check("t5_gap_locked", 32'(locked), 1);
            next_cycle();
        end
        set_req(1, 1'b1, 3'h2, 1'b1);
        @(negedge sys_clk);
        check("t5_resume_ready",  32'(req_ready), 32'b0010);
        check("t5_resume_locked", 32'(locked), 1);
        next_cycle();
        req_valid[1] = 1'b0;
        @(negedge sys_clk);
        check("t5_after_ready",  32'(req_ready), 32'b0001);
        check("t5_after_locked", 32'(locked), 0);
        next_cycle();
        req_valid = '0;
        req_last  = '0;
        // ptr now 1

        // ---------------- reset during a locked packet ----------------
        set_req(1, 1'b1, 3'h7, 1'b0);
        push(1, 7, 0);
        @(negedge sys_clk); check("t6_ready", 32'(req_ready), 32'b0010);
        next_cycle();
        set_req(1, 1'b1, 3'h3, 1'b0);
        @(negedge sys_clk);
        check("t6_pre_valid",  32'(out_valid), 1);
        check("t6_pre_locked", 32'(locked), 1);
        req_valid = '0;
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid",  32'(out_valid), 0);
        check("t6_rst_locked", 32'(locked),    0);
        check("t6_rst_src",    32'(out_src),   0);
        check("t6_rst_data",   32'(out_data),  0);
        check("t6_rst_last",   32'(out_last),  0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, DW'(i + 1), 1'b1);
        push(0, 1, 1);
        #1;
        check("t6_restart_ptr0", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = '0;
        repeat (3) next_cycle();

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
